mmu_sv32_walker: RTL and testbench

Sv32 hardware page-table walker that services TLB misses. It sits directly downstream of a TLB's MMU request port and upstream of a 32-bit read-only memory port. On a held TLB request it performs up to two PTE reads and checks permissions. It then returns either a 20-bit physical page number with a write-entry pulse, or a fault pulse. It does not update PTE A/D bits; a clear A, or a clear D on a store, is reported as a fault.

---
 rtl/mmu_sv32_walker.sv | 186 ++++++++++++++++++
 tb/tb_mmu_sv32_walker.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_sv32_walker.sv
// Sv32 page-table walker: resolves a TLB miss with up to two PTE reads and
// returns either a leaf PPN (write_entry pulse) or a page fault pulse.
module mmu_sv32_walker #(
    parameter int SATP_PPN_W = 22
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SATP_PPN_W-1:0] satp_ppn,
    input  logic [1:0]            privilege,
    input  logic                  mxr,
    input  logic                  sum,
    input  logic                  abort_request,
    input  logic                  tlb_request,
    input  logic [31:0]           tlb_virtual_address,
    input  logic                  tlb_execute,
    input  logic                  tlb_rnw,
    output logic                  tlb_write_entry,
    output logic                  tlb_is_fault,
    output logic [19:0]           tlb_upper_physical_address,
    output logic                  mem_request,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_data_valid,
    input  logic [31:0]           mem_data
);
    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L0_REQ,
        L0_WAIT,
        DONE,
        DRAIN
    } state_t;

    state_t      state_reg, state_next;
    logic [19:0] vpn_reg, vpn_next;
    logic        execute_reg, execute_next;
    logic        rnw_reg, rnw_next;
    logic [31:0] addr_reg, addr_next;
    logic [19:0] ppn_reg, ppn_next;
    logic        ok_reg, ok_next;

    logic        pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
    logic        at_l1, pte_invalid, pte_leaf, misaligned;
    logic        access_ok, priv_ok, perm_ok;
    logic [19:0] leaf_ppn;

    assign pte_v = mem_data[0];
    assign pte_r = mem_data[1];
    assign pte_w = mem_data[2];
    assign pte_x = mem_data[3];
    assign pte_u = mem_data[4];
    assign pte_a = mem_data[6];
    assign pte_d = mem_data[7];

    assign at_l1       = (state_reg == L1_WAIT);
    assign pte_invalid = !pte_v || (!pte_r && pte_w);
    assign pte_leaf    = pte_r || pte_x;
    assign misaligned  = at_l1 && (mem_data[19:10] != 10'd0);

    // Operation type is latched; privilege, mxr and sum are used live.
    assign access_ok = execute_reg ? pte_x
                     : rnw_reg     ? (pte_r || (pte_x && mxr))
                     :               (pte_w && pte_d);
    assign priv_ok   = (privilege == 2'b00)             ? pte_u
                     : ((privilege == 2'b01) && pte_u)  ? (sum && !execute_reg)
                     :                                    1'b1;
    assign perm_ok   = access_ok && priv_ok && pte_a;

    // A superpage keeps the VA's second-level index as the low PPN bits.
    assign leaf_ppn = at_l1 ? {mem_data[29:20], vpn_reg[9:0]} : mem_data[29:10];

    always_comb begin
        state_next      = state_reg;
        vpn_next        = vpn_reg;
        execute_next    = execute_reg;
        rnw_next        = rnw_reg;
        addr_next       = addr_reg;
        ppn_next        = ppn_reg;
        ok_next         = ok_reg;
        mem_request     = 1'b0;
        tlb_write_entry = 1'b0;
        tlb_is_fault    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (tlb_request && !abort_request) begin
                    state_next   = L1_REQ;
                    vpn_next     = tlb_virtual_address[31:12];
                    execute_next = tlb_execute;
                    rnw_next     = tlb_rnw;
                    addr_next    = {satp_ppn[19:0], tlb_virtual_address[31:22], 2'b00};
                end
            end
            L1_REQ, L0_REQ: begin
                if (abort_request) begin
                    state_next = IDLE;
                end else begin
                    mem_request = 1'b1;
                    if (mem_ack) begin
                        if (state_reg == L1_REQ) begin
                            state_next = L1_WAIT;
                        end else begin
                            state_next = L0_WAIT;
                        end
                    end
                end
            end
            L1_WAIT, L0_WAIT: begin
                if (mem_data_valid) begin
                    if (abort_request) begin
                        state_next = IDLE;
                    end else if (pte_invalid) begin
                        ok_next    = 1'b0;
                        state_next = DONE;
                    end else if (!pte_leaf) begin
                        if (at_l1) begin
                            addr_next  = {mem_data[29:10], vpn_reg[9:0], 2'b00};
                            state_next = L0_REQ;
                        end else begin
                            ok_next    = 1'b0;
                            state_next = DONE;
                        end
                    end else if (misaligned || !perm_ok) begin
                        ok_next    = 1'b0;
                        state_next = DONE;
                    end else begin
                        ok_next    = 1'b1;
                        ppn_next   = leaf_ppn;
                        state_next = DONE;
                    end
                end else if (abort_request) begin
                    state_next = DRAIN;
                end
            end
            DONE: begin
                tlb_write_entry = ok_reg;
                tlb_is_fault    = !ok_reg;
                state_next      = IDLE;
            end
            DRAIN: begin
                if (mem_data_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            vpn_reg     <= '0;
            execute_reg <= 1'b0;
            rnw_reg     <= 1'b0;
            addr_reg    <= '0;
            ppn_reg     <= '0;
            ok_reg      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            vpn_reg     <= vpn_next;
            execute_reg <= execute_next;
            rnw_reg     <= rnw_next;
            addr_reg    <= addr_next;
            ppn_reg     <= ppn_next;
            ok_reg      <= ok_next;
        end
    end

    assign mem_addr                   = addr_reg;
    assign tlb_upper_physical_address = ppn_reg;

    // Page offset, RSW/G bits and PTE/satp bits above the 32-bit physical space.
    logic unused_bits;
    generate
        if (SATP_PPN_W > 20) begin : g_satp_wide
            assign unused_bits = ^{satp_ppn[SATP_PPN_W-1:20], tlb_virtual_address[11:0],
                                   mem_data[31:30], mem_data[9:8], mem_data[5]};
        end else begin : g_satp_exact
            assign unused_bits = ^{tlb_virtual_address[11:0],
                                   mem_data[31:30], mem_data[9:8], mem_data[5]};
        end
    endgenerate

endmodule

// File: tb/tb_mmu_sv32_walker.sv
// Directed bench for mmu_sv32_walker: a memory responder, a spec-level walk
// model and a per-cycle compare process, plus literal pins from the test plan.
`timescale 1ns/1ps
module tb_mmu_sv32_walker;
    logic        clk = 1'b0;
    logic        rst;
    logic [21:0] satp_ppn;
    logic [1:0]  privilege;
    logic        mxr, sum, abort_request, tlb_request;
    logic [31:0] tlb_virtual_address;
    logic        tlb_execute, tlb_rnw;
    logic        tlb_write_entry, tlb_is_fault;
    logic [19:0] tlb_upper_physical_address;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic        mem_ack, mem_data_valid;
    logic [31:0] mem_data;

    always #5 clk = ~clk;

    mmu_sv32_walker #(.SATP_PPN_W(22)) dut (
        .clk(clk), .rst(rst), .satp_ppn(satp_ppn), .privilege(privilege),
        .mxr(mxr), .sum(sum), .abort_request(abort_request),
        .tlb_request(tlb_request), .tlb_virtual_address(tlb_virtual_address),
        .tlb_execute(tlb_execute), .tlb_rnw(tlb_rnw),
        .tlb_write_entry(tlb_write_entry), .tlb_is_fault(tlb_is_fault),
        .tlb_upper_physical_address(tlb_upper_physical_address),
        .mem_request(mem_request), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data)
    );

    int cmp_count = 0;
    int err_count = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] pte_mem [logic [31:0]];

    // Expectations for the walk currently presented to the DUT
    bit          exp_live = 0;
    bit          exp_walk = 0;
    bit          exp_fault = 0;
    logic [19:0] exp_ppn = '0;
    logic [31:0] exp_addr [2];
    int          exp_n = 0;

    // Observations
    int          pulse_count = 0, pulse_cyc = 0, walk_reads = 0, data_count = 0;
    bit          pulse_fault = 0;
    logic [19:0] pulse_ppn = '0;
    logic [31:0] acked_addr [2];
    int          ack_delay = 0, data_delay = 0;
    int          walk_start = 0, pulses_at_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sv32 translation straight from the privileged-spec walk: loop over levels.
    function automatic void model_walk(input logic [19:0] root, input logic [31:0] va,
                                       input bit exec, input bit rnw, input logic [1:0] priv,
                                       input bit mxr_i, input bit sum_i,
                                       output bit fault, output logic [19:0] ppn, output int n,
                                       output logic [31:0] a0, output logic [31:0] a1);
        logic [31:0] table_base, addr, pte;
        int          vpn;
        bit          ok;
        table_base = {12'd0, root} * 32'd4096;
        fault = 1; ppn = '0; n = 0; a0 = '0; a1 = '0;
        for (int level = 1; level >= 0; level--) begin
            vpn  = (level == 1) ? int'(va >> 22) : int'((va >> 12) & 32'h3FF);
            addr = table_base + 32'(vpn) * 32'd4;
            if (n == 0) a0 = addr; else a1 = addr;
            n++;
            pte = pte_mem.exists(addr) ? pte_mem[addr] : 32'h0;
            if (!pte[0] || (!pte[1] && pte[2])) return;
            if (pte[1] || pte[3]) begin
                if (level == 1 && ((pte >> 10) & 32'h3FF) != 0) return;
                ok = pte[6];
                if (exec) ok = ok && pte[3];
                else if (rnw) ok = ok && (pte[1] || (pte[3] && mxr_i));
                else ok = ok && pte[2] && pte[7];
                if (priv == 2'b00 && !pte[4]) ok = 0;
                if (priv == 2'b01 && pte[4] && (!sum_i || exec)) ok = 0;
                if (!ok) return;
                fault = 0;
                if (level == 1) ppn = 20'(((pte >> 20) & 32'h3FF) * 32'd1024 + ((va >> 12) & 32'h3FF));
                else ppn = 20'((pte >> 10) & 32'hFFFFF);
                return;
            end
            table_base = ((pte >> 10) & 32'hFFFFF) * 32'd4096;
        end
    endfunction

    // Memory responder: ack after ack_delay request cycles, data data_delay cycles later.
    initial begin
        bit          pend;
        int          pend_cnt, ack_cnt;
        logic [31:0] pend_addr;
        pend = 0; pend_cnt = 0; ack_cnt = 0; pend_addr = '0;
        mem_ack = 0; mem_data_valid = 0; mem_data = '0;
        forever begin
            @(negedge clk); #1;
            mem_ack = 0; mem_data_valid = 0; mem_data = '0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mem_data_valid = 1;
                    mem_data = pte_mem.exists(pend_addr) ? pte_mem[pend_addr] : 32'h0;
                    pend = 0;
                    data_count++;
                end else begin
                    pend_cnt--;
                end
            end
            if (mem_request && !pend) begin
                if (ack_cnt >= ack_delay) begin
                    mem_ack = 1;
                    pend = 1; pend_cnt = data_delay; pend_addr = mem_addr; ack_cnt = 0;
                    if (walk_reads < 2) acked_addr[walk_reads] = mem_addr;
                    walk_reads++;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    // Compare process: every cycle out of reset
    initial begin
        bit          prev_req;
        logic [31:0] prev_addr;
        prev_req = 0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 0;
                continue;
            end
            if (tlb_write_entry || tlb_is_fault) begin
                pulse_count++;
                pulse_cyc   = cyc;
                pulse_fault = tlb_is_fault;
                pulse_ppn   = tlb_upper_physical_address;
                check("single_pulse_kind", 32'(tlb_write_entry & tlb_is_fault), 32'd0);
                check("pulse_expected", 32'(exp_live), 32'd1);
                if (exp_live) begin
                    check("is_fault", 32'(tlb_is_fault), 32'(exp_fault));
                    if (!exp_fault) check("ppn", 32'(tlb_upper_physical_address), 32'(exp_ppn));
                end
            end
            if (mem_request) begin
                check("request_expected", 32'(exp_walk), 32'd1);
                check("read_in_budget", 32'(walk_reads < exp_n), 32'd1);
                if (exp_walk && walk_reads < exp_n && walk_reads < 2)
                    check("mem_addr", mem_addr, exp_addr[walk_reads]);
            end
            if (prev_req && !mem_ack && !abort_request) begin
                check("req_held", 32'(mem_request), 32'd1);
                check("addr_held", mem_addr, prev_addr);
            end
            prev_req  = mem_request;
            prev_addr = mem_addr;
        end
    end

    task automatic start_walk(input logic [21:0] satp, input logic [31:0] va, input bit exec,
                              input bit rnw, input logic [1:0] priv, input bit mxr_i,
                              input bit sum_i, input bit live);
        bit          f;
        logic [19:0] p;
        int          n;
        logic [31:0] a0, a1;
        @(posedge clk); #1;
        model_walk(satp[19:0], va, exec, rnw, priv, mxr_i, sum_i, f, p, n, a0, a1);
        exp_fault = f; exp_ppn = p; exp_n = n; exp_addr[0] = a0; exp_addr[1] = a1;
        walk_reads = 0; exp_live = live; exp_walk = 1; pulses_at_start = pulse_count;
        satp_ppn = satp; tlb_virtual_address = va; tlb_execute = exec; tlb_rnw = rnw;
        privilege = priv; mxr = mxr_i; sum = sum_i; tlb_request = 1;
        walk_start = cyc;
    endtask

    task automatic finish_walk(input string tag, output int latency);
        int t;
        t = 0;
        while (pulse_count == pulses_at_start && t < 300) begin
            @(negedge clk); #2;
            t++;
        end
        check({tag, "_no_timeout"}, 32'(t < 300), 32'd1);
        latency = pulse_cyc - walk_start;
        @(posedge clk); #1;
        tlb_request = 0; exp_live = 0; exp_walk = 0;
        repeat (3) @(negedge clk);
        #2;
        check({tag, "_pulse_count"}, 32'(pulse_count - pulses_at_start), 32'd1);
        $display("%-16s va=%08h fault=%0d ppn=%05h latency=%0d", tag, tlb_virtual_address,
                 pulse_fault, pulse_ppn, latency);
    endtask

    typedef struct {
        logic [31:0] va;
        bit          exec;
        bit          rnw;
        logic [1:0]  priv;
        bit          mxr_v;
        bit          sum_v;
        bit          fault;
        int          lat;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat, dc, t;
        pte_mem[32'h00080400] = 32'h200000CF;
        pte_mem[32'h0010000C] = 32'h00024001;
        pte_mem[32'h00090014] = 32'h000300D7;
        pte_mem[32'h00200004] = 32'h200000CE;
        pte_mem[32'h00200008] = 32'h200004CF;
        pte_mem[32'h0020000C] = 32'h2000004F;
        pte_mem[32'h00200010] = 32'h200000CF;
        pte_mem[32'h00200014] = 32'h00024001;
        pte_mem[32'h0009001C] = 32'h00000001;
        pte_mem[32'h00200018] = 32'h20000049;
        pte_mem[32'h0020001C] = 32'h200000DB;

        vecs[0] = '{32'h00400000, 0, 1, 2'b01, 0, 0, 1, 3};
        vecs[1] = '{32'h00800000, 0, 1, 2'b01, 0, 0, 1, 3};
        vecs[2] = '{32'h00C00000, 0, 0, 2'b01, 0, 0, 1, 3};
        vecs[3] = '{32'h01000000, 0, 1, 2'b00, 0, 0, 1, 3};
        vecs[4] = '{32'h01407000, 0, 1, 2'b01, 0, 0, 1, 5};
        vecs[5] = '{32'h01800000, 0, 1, 2'b01, 0, 0, 1, 3};
        vecs[6] = '{32'h01800000, 0, 1, 2'b01, 1, 0, 0, 3};
        vecs[7] = '{32'h01C00000, 0, 1, 2'b01, 0, 0, 1, 3};
        vecs[8] = '{32'h01C00000, 0, 1, 2'b01, 0, 1, 0, 3};
        vecs[9] = '{32'h01C00000, 1, 0, 2'b01, 0, 1, 1, 3};

        rst = 1; satp_ppn = '0; privilege = 2'b01; mxr = 0; sum = 0;
        abort_request = 0; tlb_request = 0; tlb_virtual_address = '0;
        tlb_execute = 0; tlb_rnw = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_request", 32'(mem_request), 32'd0);
        check("rst_write_entry", 32'(tlb_write_entry), 32'd0);
        check("rst_is_fault", 32'(tlb_is_fault), 32'd0);
        check("rst_ppn", 32'(tlb_upper_physical_address), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 0;

        // Superpage load; satp bits above 19 must be ignored
        start_walk(22'h300080, 32'h40123456, 0, 1, 2'b01, 0, 0, 1);
        finish_walk("superpage_load", lat);
        check("sp_l1_addr", acked_addr[0], 32'h00080400);
        check("sp_latency", 32'(lat), 32'd3);
        check("sp_fault", 32'(pulse_fault), 32'd0);
        check("sp_ppn", 32'(pulse_ppn), 32'h80123);

        // Two-level store in U mode
        start_walk(22'h000100, 32'h00C05000, 0, 0, 2'b00, 0, 0, 1);
        finish_walk("two_level_store", lat);
        check("tl_l0_addr", acked_addr[1], 32'h00090014);
        check("tl_latency", 32'(lat), 32'd5);
        check("tl_fault", 32'(pulse_fault), 32'd0);
        check("tl_ppn", 32'(pulse_ppn), 32'h000C0);

        // Fault and mxr/sum vectors
        for (int i = 0; i < 10; i++) begin
            start_walk(22'h000200, vecs[i].va, vecs[i].exec, vecs[i].rnw, vecs[i].priv,
                       vecs[i].mxr_v, vecs[i].sum_v, 1);
            finish_walk($sformatf("vec%0d", i), lat);
            check($sformatf("vec%0d_fault", i), 32'(pulse_fault), 32'(vecs[i].fault));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: ack withheld for 5 request cycles
        ack_delay = 5;
        start_walk(22'h000080, 32'h40123456, 0, 1, 2'b01, 0, 0, 1);
        finish_walk("backpressure", lat);
        check("bp_latency", 32'(lat), 32'd8);
        check("bp_ppn", 32'(pulse_ppn), 32'h80123);

        // Abort while in L1_REQ: request drops the same cycle, no read issued
        ack_delay = 100;
        start_walk(22'h000080, 32'h40123456, 0, 1, 2'b01, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort_request = 1;
        #1;
        check("abort_req_drop", 32'(mem_request), 32'd0);
        @(posedge clk); #1;
        abort_request = 0; tlb_request = 0;
        repeat (4) @(negedge clk);
        #2;
        check("abort_req_reads", 32'(walk_reads), 32'd0);
        check("abort_req_pulses", 32'(pulse_count - pulses_at_start), 32'd0);
        exp_walk = 0; ack_delay = 0;
        $display("abort_l1_req     reads=%0d pulses=%0d", walk_reads, pulse_count - pulses_at_start);

        // Abort in L0_WAIT with data 4 cycles late, then a new request during drain
        data_delay = 4;
        start_walk(22'h000100, 32'h00C05000, 0, 0, 2'b00, 0, 0, 0);
        t = 0;
        while (walk_reads < 2 && t < 100) begin
            @(negedge clk); #2;
            t++;
        end
        check("abort_wait_reach_l0", 32'(walk_reads), 32'd2);
        @(posedge clk); #1;
        abort_request = 1;
        dc = data_count;
        @(posedge clk); #1;
        abort_request = 0; tlb_request = 0;
        data_delay = 0;
        start_walk(22'h000080, 32'h40123456, 0, 1, 2'b01, 0, 0, 1);
        t = 0;
        while (data_count == dc && t < 50) begin
            @(negedge clk); #2;
            check("drain_no_request", 32'(mem_request), 32'd0);
            t++;
        end
        check("drain_data_seen", 32'(data_count - dc), 32'd1);
        finish_walk("after_abort", lat);
        check("after_abort_fault", 32'(pulse_fault), 32'd0);
        check("after_abort_ppn", 32'(pulse_ppn), 32'h80123);

        // Reset during L1_WAIT; late data must be ignored
        data_delay = 3;
        start_walk(22'h000080, 32'h40123456, 0, 1, 2'b01, 0, 0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1; tlb_request = 0;
        dc = data_count;
        @(posedge clk); #1;
        check("midrst_mem_request", 32'(mem_request), 32'd0);
        check("midrst_ppn", 32'(tlb_upper_physical_address), 32'd0);
        rst = 0; data_delay = 0;
        t = 0;
        while (data_count == dc && t < 50) begin
            @(negedge clk); #2;
            t++;
        end
        repeat (3) @(negedge clk);
        #2;
        check("midrst_pulses", 32'(pulse_count - pulses_at_start), 32'd0);
        check("midrst_idle", 32'(mem_request), 32'd0);
        exp_walk = 0;
        $display("reset_mid_walk   pulses=%0d", pulse_count - pulses_at_start);

        start_walk(22'h000080, 32'h40123456, 0, 1, 2'b01, 0, 0, 1);
        finish_walk("after_reset", lat);
        check("after_reset_latency", 32'(lat), 32'd3);
        check("after_reset_ppn", 32'(pulse_ppn), 32'h80123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, want completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
